lfsr_checker: RTL

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - PRBS byte checker: hunts, syncs and locks onto an 8-bit LFSR stream, counts errors
module lfsr_checker #(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOST_N = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       clr_err,
  output logic       locked,
  output logic       err_pulse,
  output logic [7:0] err_cnt,
  output logic [6:0] seg_hi,
  output logic [6:0] seg_lo
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_N);
  localparam logic [3:0] LOST_LIM = 4'(LOST_N);

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t     state, state_nx;
  logic [7:0] pred, pred_nx;
  logic [3:0] match_cnt, match_nx;
  logic [3:0] miss_cnt, miss_nx;
  logic       err_hit;
  logic [7:0] err_cnt_nx;
  logic [3:0] match_inc, miss_inc;

  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;

  always_comb begin
    state_nx = state;
    pred_nx  = pred;
    match_nx = match_cnt;
    miss_nx  = miss_cnt;
    err_hit  = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data != 8'h00) begin
            pred_nx  = lfsr_next(in_data);
            match_nx = 4'd0;
            state_nx = SYNC;
          end
        end
        SYNC: begin
          if (in_data == pred) begin
            pred_nx  = lfsr_next(in_data);
            match_nx = match_inc;
            if (match_inc == LOCK_LIM) begin
              state_nx = LOCK;
              miss_nx  = 4'd0;
            end
          end else if (in_data != 8'h00) begin
            // reseed from the offending byte rather than dropping to HUNT
            pred_nx  = lfsr_next(in_data);
            match_nx = 4'd0;
          end else begin
            state_nx = HUNT;
          end
        end
        LOCK: begin
          // predictor free-runs so a corrupted byte cannot derail it
          pred_nx = lfsr_next(pred);
          if (in_data == pred) begin
            miss_nx = 4'd0;
          end else begin
            err_hit = 1'b1;
            miss_nx = miss_inc;
            if (miss_inc == LOST_LIM) state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_comb begin
    err_cnt_nx = err_cnt;
    if (clr_err)
      err_cnt_nx = 8'h00;
    else if (err_hit && err_cnt != 8'hFF)
      err_cnt_nx = err_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      pred      <= 8'h00;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= 8'h00;
    end else begin
      state     <= state_nx;
      pred      <= pred_nx;
      match_cnt <= match_nx;
      miss_cnt  <= miss_nx;
      locked    <= (state_nx == LOCK);
      err_pulse <= err_hit;
      err_cnt   <= err_cnt_nx;
    end
  end

  assign seg_hi = seg7(err_cnt[7:4]);
  assign seg_lo = seg7(err_cnt[3:0]);

endmodule
